// File: rtl/mc_alu.sv
// Multi-cycle execution ALU: single-cycle logic/arith/branch ops plus a
// WIDTH-iteration restoring signed divider behind an in_valid/in_ready + done handshake.
module mc_alu #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNTW  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CNTW-1:0]  ALUcntrl,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             done,
  output logic [WIDTH-1:0] ALUresult,
  output logic [WIDTH-1:0] rem,
  output logic             zero,
  output logic             dbz
);

  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [CNTW-1:0] OP_AND = CNTW'(0);
  localparam logic [CNTW-1:0] OP_OR  = CNTW'(1);
  localparam logic [CNTW-1:0] OP_NOR = CNTW'(2);
  localparam logic [CNTW-1:0] OP_ADD = CNTW'(3);
  localparam logic [CNTW-1:0] OP_DIV = CNTW'(4);
  localparam logic [CNTW-1:0] OP_BEQ = CNTW'(9);
  localparam logic [CNTW-1:0] OP_BLT = CNTW'(10);
  localparam logic [CNTW-1:0] OP_BNE = CNTW'(11);
  localparam logic [CNTW-1:0] OP_ONE = CNTW'(12);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DIV, S_FIX} state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [CNTW-1:0]  r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_load;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_part;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic             r_neg_q;
  logic             r_neg_r;

  logic             r_ready;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_rem;
  logic             r_zero;
  logic             r_dbz;

  logic             w_accept;
  logic             w_done_nxt;
  logic [WIDTH-1:0] w_result_nxt;
  logic [WIDTH-1:0] w_rem_nxt;
  logic             w_zero_nxt;
  logic             w_dbz_nxt;

  logic [WIDTH-1:0] w_ex_result;
  logic [WIDTH-1:0] w_ex_rem;
  logic             w_ex_zero;
  logic             w_ex_dbz;
  logic [WIDTH-1:0] w_sub;

  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic             w_qbit;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;

  assign w_accept  = in_valid & r_ready;
  assign in_ready  = r_ready;
  assign done      = r_done;
  assign ALUresult = r_result;
  assign rem       = r_rem;
  assign zero      = r_zero;
  assign dbz       = r_dbz;

  // Single-cycle result from the operands latched at accept
  always_comb begin
    w_sub       = r_a - r_b;
    w_ex_result = '0;
    w_ex_rem    = '0;
    w_ex_zero   = 1'b0;
    w_ex_dbz    = 1'b0;
    case (r_op)
      OP_AND: w_ex_result = r_a & r_b;
      OP_OR:  w_ex_result = r_a | r_b;
      OP_NOR: w_ex_result = ~(r_a | r_b);
      OP_ADD: w_ex_result = r_a + r_b;
      OP_DIV: begin
        // Only reached with a zero divisor; nonzero divisors go through S_DIV
        w_ex_result = '1;
        w_ex_rem    = r_a;
        w_ex_dbz    = 1'b1;
      end
      OP_BEQ: begin
        w_ex_result = w_sub;
        w_ex_zero   = (r_a == r_b);
      end
      OP_BLT: begin
        w_ex_result = w_sub;
        w_ex_zero   = ($signed(r_a) < $signed(r_b));
      end
      OP_BNE: begin
        w_ex_result = w_sub;
        w_ex_zero   = (r_a != r_b);
      end
      OP_ONE: begin
        w_ex_result = '0;
        w_ex_zero   = 1'b1;
      end
      default: w_ex_result = WIDTH'(1);
    endcase
  end

  // Restoring divider datapath on magnitudes; MIN maps to 2^(WIDTH-1) unsigned
  always_comb begin
    w_abs_a = r_a[WIDTH-1] ? (~r_a + WIDTH'(1)) : r_a;
    w_abs_b = r_b[WIDTH-1] ? (~r_b + WIDTH'(1)) : r_b;
    w_shift = {r_part, r_quo[WIDTH-1]};
    w_trial = w_shift - {1'b0, r_dvs};
    w_qbit  = ~w_trial[WIDTH];
    w_q_fix = r_neg_q ? (~r_quo + WIDTH'(1)) : r_quo;
    w_r_fix = r_neg_r ? (~r_part + WIDTH'(1)) : r_part;
  end

  // Next-state and registered-output next values
  always_comb begin
    w_state_nxt  = r_state;
    w_done_nxt   = 1'b0;
    w_result_nxt = r_result;
    w_rem_nxt    = r_rem;
    w_zero_nxt   = r_zero;
    w_dbz_nxt    = r_dbz;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if ((ALUcntrl == OP_DIV) && (srcB != '0)) w_state_nxt = S_DIV;
          else                                      w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        w_state_nxt  = S_IDLE;
        w_done_nxt   = 1'b1;
        w_result_nxt = w_ex_result;
        w_rem_nxt    = w_ex_rem;
        w_zero_nxt   = w_ex_zero;
        w_dbz_nxt    = w_ex_dbz;
      end
      S_DIV: begin
        if (!r_load && (r_cnt == '0)) w_state_nxt = S_FIX;
      end
      S_FIX: begin
        w_state_nxt  = S_IDLE;
        w_done_nxt   = 1'b1;
        w_result_nxt = w_q_fix;
        w_rem_nxt    = w_r_fix;
        w_zero_nxt   = 1'b0;
        w_dbz_nxt    = 1'b0;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_ready  <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_rem    <= '0;
      r_zero   <= 1'b0;
      r_dbz    <= 1'b0;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_load   <= 1'b0;
      r_cnt    <= '0;
      r_part   <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_ready  <= (w_state_nxt == S_IDLE);
      r_done   <= w_done_nxt;
      r_result <= w_result_nxt;
      r_rem    <= w_rem_nxt;
      r_zero   <= w_zero_nxt;
      r_dbz    <= w_dbz_nxt;
      if (w_accept) begin
        r_op   <= ALUcntrl;
        r_a    <= srcA;
        r_b    <= srcB;
        r_load <= 1'b1;
      end
      // First DIV cycle loads magnitudes, then one quotient bit per cycle
      if (r_state == S_DIV) begin
        if (r_load) begin
          r_load  <= 1'b0;
          r_part  <= '0;
          r_quo   <= w_abs_a;
          r_dvs   <= w_abs_b;
          r_neg_q <= r_a[WIDTH-1] ^ r_b[WIDTH-1];
          r_neg_r <= r_a[WIDTH-1];
          r_cnt   <= CW'(WIDTH - 1);
        end else begin
          r_part <= w_qbit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
          r_quo  <= {r_quo[WIDTH-2:0], w_qbit};
          r_cnt  <= r_cnt - CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mc_alu.sv
// Scoreboard bench for mc_alu: stimulus pushes expected responses, a monitor
// pops and checks them (including completion cycle) whenever done pulses.
module tb_mc_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  ALUcntrl;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        done;
  logic [31:0] ALUresult;
  logic [31:0] rem;
  logic        zero;
  logic        dbz;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic [31:0] rm;
    logic        z;
    logic        d;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  mc_alu #(.WIDTH(32), .CNTW(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ALUcntrl(ALUcntrl), .srcA(srcA), .srcB(srcB), .done(done),
    .ALUresult(ALUresult), .rem(rem), .zero(zero), .dbz(dbz)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done with empty scoreboard, expected none");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, ".result"}, ALUresult, e.res);
        chk({e.name, ".rem"}, rem, e.rm);
        chk({e.name, ".zero"}, 32'(zero), 32'(e.z));
        chk({e.name, ".dbz"}, 32'(dbz), 32'(e.d));
        chk({e.name, ".done_cycle"}, 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic issue(input string nm, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] er, input logic [31:0] erm,
                       input logic ez, input logic ed, input int lat);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s.ready_timeout: in_ready stayed 0, expected 1", nm);
      return;
    end
    in_valid = 1'b1;
    ALUcntrl = op;
    srcA     = a;
    srcB     = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    e.name = nm; e.res = er; e.rm = erm; e.z = ez; e.d = ed; e.cyc = cyc + lat;
    sb.push_back(e);
  endtask

  initial begin
    int bad_ready;
    int n;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    ALUcntrl = '0;
    srcA     = '0;
    srcB     = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.result", ALUresult, 32'h0);
    chk("reset.in_ready", 32'(in_ready), 32'h0);
    chk("reset.done", 32'(done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset.in_ready", 32'(in_ready), 32'h1);

    issue("add_wrap", 4'd3,  32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 0, 1'b0, 1'b0, 1);
    issue("blt_min",  4'd10, 32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 0, 1'b1, 1'b0, 1);
    issue("blt_not",  4'd10, 32'h1,         32'h8000_0000, 32'h8000_0001, 0, 1'b0, 1'b0, 1);
    issue("beq_eq",   4'd9,  32'd5,         32'd5,         32'h0,         0, 1'b1, 1'b0, 1);
    issue("bne_eq",   4'd11, 32'd5,         32'd5,         32'h0,         0, 1'b0, 1'b0, 1);
    issue("op12",     4'd12, 32'd3,         32'd4,         32'h0,         0, 1'b1, 1'b0, 1);
    issue("and",      4'd0,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 0, 1'b0, 1'b0, 1);
    issue("or",       4'd1,  32'h0000_00F0, 32'h0000_0F00, 32'h0000_0FF0, 0, 1'b0, 1'b0, 1);
    issue("nor",      4'd2,  32'h0,         32'h0,         32'hFFFF_FFFF, 0, 1'b0, 1'b0, 1);
    issue("op7",      4'd7,  32'd9,         32'd9,         32'h1,         0, 1'b0, 1'b0, 1);

    // Divide with in_valid pulses that must be ignored while busy
    issue("div_m7_2", 4'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0, 34);
    bad_ready = 0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) break;
      n++;
      if (in_ready) bad_ready++;
      in_valid = i[0];
      ALUcntrl = 4'd3;
      srcA     = 32'd1;
      srcB     = 32'd1;
    end
    in_valid = 1'b0;
    chk("div_busy.ready_high_cycles", 32'(bad_ready), 32'h0);
    chk("div_busy.busy_cycles", 32'(n), 32'd34);

    issue("div_7_m2",  4'd4, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0, 34);
    issue("div_by0",   4'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5, 1'b0, 1'b1, 1);
    issue("div_min",   4'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1'b0, 34);
    issue("div_100_7", 4'd4, 32'd100,       32'd7,         32'd14,        32'd2, 1'b0, 1'b0, 34);
    issue("beq_after", 4'd9, 32'd5,         32'd6,         32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 1);
    issue("div_17_5",  4'd4, 32'd17,        32'd5,         32'd3,         32'd2, 1'b0, 1'b0, 34);

    // Reset 10 cycles into a divide: abandoned, outputs cleared, no done
    issue("div_abort", 4'd4, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 1'b0, 34);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("abort.result", ALUresult, 32'h0);
    chk("abort.rem", rem, 32'h0);
    chk("abort.flags", {29'h0, zero, dbz, done}, 32'h0);
    chk("abort.in_ready", 32'(in_ready), 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release.in_ready_before_edge", 32'(in_ready), 32'h0);
    @(posedge clk);
    #1;
    chk("release.in_ready_after_edge", 32'(in_ready), 32'h1);
    issue("or_after_reset", 4'd1, 32'h12, 32'h21, 32'h33, 32'h0, 1'b0, 1'b0, 1);

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
